// File: rtl/weight_addr_gen.sv
// Weight-memory address generator for a systolic tile.
// Walks block rows (outer), column groups (middle) and the S2P rows of a
// block (inner), presenting one S2P-word burst start address per beat.
// Addresses are built with adders only: row_base steps by L per row,
// col_off steps by S2P per column group, blk_base steps by S2P*L per block.

`ifndef S2P_SIZE
`define S2P_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif

module weight_addr_gen #(
    parameter int S2P    = `S2P_SIZE,
    parameter int ADDR_W = `ADDR_SIZE,
    parameter int KKC_W  = 2*`KERNEL_SIZE+`CHANNELS_SIZE,
    parameter int KN_W   = `KERNEL_NUMS_SIZE
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic [KKC_W-1:0]  i_w_addr_bcn,
    input  logic [KN_W-1:0]   i_w_addr_brn,
    input  logic [KKC_W-1:0]  i_w_addr_iww,
    input  logic [S2P-1:0]    i_w_addr_knr,
    input  logic [S2P-1:0]    i_w_addr_iwwr,
    input  logic              i_w_ready,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_w_valid,
    output logic              o_w_row_vld,
    output logic [S2P-1:0]    o_w_lane_mask,
    output logic              o_w_done
);

    // state | meaning
    // IDLE  | waiting for a sampled enable=1; parameters latched on exit
    // RUN   | presenting beats, advancing on valid && ready
    // DONE  | sequence finished, done pulsed once; waits for enable=0

    localparam int RW = (S2P > 1) ? $clog2(S2P) : 1;
    localparam logic [KN_W-1:0]   KN_ONE   = 1;
    localparam logic [RW-1:0]     ROW_LAST = RW'(S2P-1);
    localparam logic [ADDR_W-1:0] S2P_A    = ADDR_W'(S2P);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [KKC_W-1:0]    bcn_q;
    logic [KN_W-1:0]     brn_q;
    logic [KKC_W-1:0]    iww_q;
    logic [S2P-1:0]      knr_q;
    logic [S2P-1:0]      iwwr_q;
    logic [RW-1:0]       row_cnt;
    logic [KKC_W-1:0]    bc_cnt;
    logic [KN_W-1:0]     br_cnt;
    logic [ADDR_W-1:0]   row_base;
    logic [ADDR_W-1:0]   blk_base;
    logic [ADDR_W-1:0]   col_off;

    logic [RW-1:0]       nxt_row;
    logic [KKC_W-1:0]    nxt_bc;
    logic [KN_W-1:0]     nxt_br;
    logic [ADDR_W-1:0]   nxt_row_base;
    logic [ADDR_W-1:0]   nxt_blk_base;
    logic [ADDR_W-1:0]   nxt_col_off;
    logic                last_beat;
    logic                nxt_rv;
    logic [S2P-1:0]      nxt_mask;
    logic                st_rv;
    logic [S2P-1:0]      st_mask;
    logic [ADDR_W-1:0]   len_a;

    // Rows beyond knr in the final block row are padding.
    function automatic logic f_row_vld(input logic [KN_W-1:0] br,
                                       input logic [KN_W-1:0] brn,
                                       input logic [RW-1:0]   i,
                                       input logic [S2P-1:0]  knr);
        return !((br == brn - KN_ONE) && (S2P'(i) > knr));
    endfunction

    // Only the last column group is partial; padding rows get no lanes.
    function automatic logic [S2P-1:0] f_mask(input logic [KKC_W-1:0] bc,
                                              input logic [KKC_W-1:0] bcn,
                                              input logic [S2P-1:0]   iwwr,
                                              input logic             rv);
        logic [S2P-1:0] m;
        for (int j = 0; j < S2P; j++)
            m[j] = (bc != bcn) || (S2P'(j) <= iwwr);
        return rv ? m : '0;
    endfunction

    assign len_a   = ADDR_W'(iww_q);
    assign st_rv   = f_row_vld('0, i_w_addr_brn, '0, i_w_addr_knr);
    assign st_mask = f_mask('0, i_w_addr_bcn, i_w_addr_iwwr, st_rv);
    assign nxt_rv  = f_row_vld(nxt_br, brn_q, nxt_row, knr_q);
    assign nxt_mask = f_mask(nxt_bc, bcn_q, iwwr_q, nxt_rv);

    // Next beat position and address bases after the current beat is accepted.
    always_comb begin
        nxt_row      = row_cnt;
        nxt_bc       = bc_cnt;
        nxt_br       = br_cnt;
        nxt_row_base = row_base;
        nxt_blk_base = blk_base;
        nxt_col_off  = col_off;
        last_beat    = 1'b0;
        if (row_cnt != ROW_LAST) begin
            nxt_row      = row_cnt + 1'b1;
            nxt_row_base = row_base + len_a;
        end else if (bc_cnt != bcn_q) begin
            nxt_row      = '0;
            nxt_bc       = bc_cnt + 1'b1;
            nxt_row_base = blk_base;
            nxt_col_off  = col_off + S2P_A;
        end else if (br_cnt != brn_q - KN_ONE) begin
            // the row after the block's last row is the next block's base
            nxt_row      = '0;
            nxt_bc       = '0;
            nxt_br       = br_cnt + 1'b1;
            nxt_row_base = row_base + len_a;
            nxt_blk_base = row_base + len_a;
            nxt_col_off  = '0;
        end else begin
            last_beat = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs; enable=0 aborts from any state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            bcn_q         <= '0;
            brn_q         <= '0;
            iww_q         <= '0;
            knr_q         <= '0;
            iwwr_q        <= '0;
            row_cnt       <= '0;
            bc_cnt        <= '0;
            br_cnt        <= '0;
            row_base      <= '0;
            blk_base      <= '0;
            col_off       <= '0;
            o_w_addr      <= '0;
            o_w_valid     <= 1'b0;
            o_w_row_vld   <= 1'b0;
            o_w_lane_mask <= '0;
            o_w_done      <= 1'b0;
        end else if (!enable) begin
            state         <= IDLE;
            row_cnt       <= '0;
            bc_cnt        <= '0;
            br_cnt        <= '0;
            row_base      <= '0;
            blk_base      <= '0;
            col_off       <= '0;
            o_w_addr      <= '0;
            o_w_valid     <= 1'b0;
            o_w_row_vld   <= 1'b0;
            o_w_lane_mask <= '0;
            o_w_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bcn_q    <= i_w_addr_bcn;
                    brn_q    <= i_w_addr_brn;
                    iww_q    <= i_w_addr_iww;
                    knr_q    <= i_w_addr_knr;
                    iwwr_q   <= i_w_addr_iwwr;
                    row_cnt  <= '0;
                    bc_cnt   <= '0;
                    br_cnt   <= '0;
                    row_base <= '0;
                    blk_base <= '0;
                    col_off  <= '0;
                    o_w_addr <= '0;
                    if (i_w_addr_brn == '0) begin
                        state    <= DONE;
                        o_w_done <= 1'b1;
                    end else begin
                        state         <= RUN;
                        o_w_valid     <= 1'b1;
                        o_w_row_vld   <= st_rv;
                        o_w_lane_mask <= st_mask;
                    end
                end
                RUN: begin
                    if (o_w_valid && i_w_ready) begin
                        if (last_beat) begin
                            state         <= DONE;
                            o_w_valid     <= 1'b0;
                            o_w_row_vld   <= 1'b0;
                            o_w_lane_mask <= '0;
                            o_w_done      <= 1'b1;
                        end else begin
                            row_cnt       <= nxt_row;
                            bc_cnt        <= nxt_bc;
                            br_cnt        <= nxt_br;
                            row_base      <= nxt_row_base;
                            blk_base      <= nxt_blk_base;
                            col_off       <= nxt_col_off;
                            o_w_addr      <= nxt_row_base + nxt_col_off;
                            o_w_row_vld   <= nxt_rv;
                            o_w_lane_mask <= nxt_mask;
                        end
                    end
                end
                DONE: begin
                    o_w_valid <= 1'b0;
                    o_w_done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_addr_gen.sv
// Directed bench for weight_addr_gen with S2P=4 and hand-computed beats.
`timescale 1ns/1ps
module tb_weight_addr_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [15:0] bcn;
    logic [7:0]  brn;
    logic [15:0] iww;
    logic [3:0]  knr;
    logic [3:0]  iwwr;
    logic        ready;
    logic [15:0] addr;
    logic        valid;
    logic        row_vld;
    logic [3:0]  mask;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    weight_addr_gen #(.S2P(4), .ADDR_W(16), .KKC_W(16), .KN_W(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .i_w_addr_bcn  (bcn),
        .i_w_addr_brn  (brn),
        .i_w_addr_iww  (iww),
        .i_w_addr_knr  (knr),
        .i_w_addr_iwwr (iwwr),
        .i_w_ready     (ready),
        .o_w_addr      (addr),
        .o_w_valid     (valid),
        .o_w_row_vld   (row_vld),
        .o_w_lane_mask (mask),
        .o_w_done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one presented beat, then let it be accepted (ready assumed high).
    task automatic beat(input string tag, input logic [15:0] a, input logic rv, input logic [3:0] m);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " addr"}, 32'(addr), 32'(a));
        chk({tag, " row_vld"}, 32'(row_vld), 32'(rv));
        chk({tag, " mask"}, 32'(mask), 32'(m));
        chk({tag, " done"}, 32'(done), 32'd0);
        @(negedge clk);
    endtask

    task automatic setup_a();
        brn = 8'd1; knr = 4'hF; iww = 16'd8; bcn = 16'd1; iwwr = 4'hF;
    endtask

    task automatic seq_a(input string tag);
        beat({tag, " b0"}, 16'd0, 1'b1, 4'hF);
        beat({tag, " b1"}, 16'd8, 1'b1, 4'hF);
        beat({tag, " b2"}, 16'd16, 1'b1, 4'hF);
        beat({tag, " b3"}, 16'd24, 1'b1, 4'hF);
        beat({tag, " b4"}, 16'd4, 1'b1, 4'hF);
        beat({tag, " b5"}, 16'd12, 1'b1, 4'hF);
        beat({tag, " b6"}, 16'd20, 1'b1, 4'hF);
        beat({tag, " b7"}, 16'd28, 1'b1, 4'hF);
    endtask

    task automatic end_chk(input string tag);
        chk({tag, " end valid"}, 32'(valid), 32'd0);
        chk({tag, " end done"}, 32'(done), 32'd1);
        @(negedge clk);
        chk({tag, " post done"}, 32'(done), 32'd0);
        chk({tag, " post valid"}, 32'(valid), 32'd0);
        @(negedge clk);
        chk({tag, " hold done"}, 32'(done), 32'd0);
        chk({tag, " hold valid"}, 32'(valid), 32'd0);
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; ready = 1'b1;
        bcn = '0; brn = '0; iww = '0; knr = '0; iwwr = '0;
        #1;
        chk("rst addr", 32'(addr), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst row_vld", 32'(row_vld), 32'd0);
        chk("rst mask", 32'(mask), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle valid", 32'(valid), 32'd0);

        // basic full sequence
        setup_a(); enable = 1'b1;
        @(negedge clk);
        seq_a("t1");
        end_chk("t1");

        // partial last block row and partial last column group
        brn = 8'd2; knr = 4'd0; iww = 16'd6; bcn = 16'd1; iwwr = 4'd1;
        enable = 1'b1;
        @(negedge clk);
        brn = 8'd7; iww = 16'd99; knr = 4'd3; iwwr = 4'd3;  // ignored while running
        beat("t2 b0", 16'd0, 1'b1, 4'hF);
        beat("t2 b1", 16'd6, 1'b1, 4'hF);
        beat("t2 b2", 16'd12, 1'b1, 4'hF);
        beat("t2 b3", 16'd18, 1'b1, 4'hF);
        beat("t2 b4", 16'd4, 1'b1, 4'h3);
        beat("t2 b5", 16'd10, 1'b1, 4'h3);
        beat("t2 b6", 16'd16, 1'b1, 4'h3);
        beat("t2 b7", 16'd22, 1'b1, 4'h3);
        beat("t2 b8", 16'd24, 1'b1, 4'hF);
        beat("t2 b9", 16'd30, 1'b0, 4'h0);
        beat("t2 b10", 16'd36, 1'b0, 4'h0);
        beat("t2 b11", 16'd42, 1'b0, 4'h0);
        beat("t2 b12", 16'd28, 1'b1, 4'h3);
        beat("t2 b13", 16'd34, 1'b0, 4'h0);
        beat("t2 b14", 16'd40, 1'b0, 4'h0);
        beat("t2 b15", 16'd46, 1'b0, 4'h0);
        end_chk("t2");

        // backpressure on beat 2
        setup_a(); enable = 1'b1;
        @(negedge clk);
        beat("t3 b0", 16'd0, 1'b1, 4'hF);
        beat("t3 b1", 16'd8, 1'b1, 4'hF);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3 stall valid", 32'(valid), 32'd1);
            chk("t3 stall addr", 32'(addr), 32'd16);
            chk("t3 stall mask", 32'(mask), 32'hF);
            @(negedge clk);
        end
        ready = 1'b1;
        beat("t3 b2", 16'd16, 1'b1, 4'hF);
        beat("t3 b3", 16'd24, 1'b1, 4'hF);
        beat("t3 b4", 16'd4, 1'b1, 4'hF);
        beat("t3 b5", 16'd12, 1'b1, 4'hF);
        beat("t3 b6", 16'd20, 1'b1, 4'hF);
        beat("t3 b7", 16'd28, 1'b1, 4'hF);
        end_chk("t3");

        // zero block rows
        brn = 8'd0; enable = 1'b1;
        @(negedge clk);
        chk("t4 valid", 32'(valid), 32'd0);
        chk("t4 done", 32'(done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4 later done", 32'(done), 32'd0);
            chk("t4 later valid", 32'(valid), 32'd0);
        end
        enable = 1'b0;
        @(negedge clk);

        // abort after three beats, then restart
        setup_a(); enable = 1'b1;
        @(negedge clk);
        beat("t5 b0", 16'd0, 1'b1, 4'hF);
        beat("t5 b1", 16'd8, 1'b1, 4'hF);
        beat("t5 b2", 16'd16, 1'b1, 4'hF);
        enable = 1'b0;
        @(negedge clk);
        chk("t5 abort valid", 32'(valid), 32'd0);
        chk("t5 abort done", 32'(done), 32'd0);
        @(negedge clk);
        chk("t5 abort done2", 32'(done), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        seq_a("t5r");
        end_chk("t5r");

        // asynchronous reset mid-run
        setup_a(); enable = 1'b1;
        @(negedge clk);
        beat("t6 b0", 16'd0, 1'b1, 4'hF);
        beat("t6 b1", 16'd8, 1'b1, 4'hF);
        #2 rstn = 1'b0;
        #1;
        chk("t6 rst addr", 32'(addr), 32'd0);
        chk("t6 rst valid", 32'(valid), 32'd0);
        chk("t6 rst row_vld", 32'(row_vld), 32'd0);
        chk("t6 rst mask", 32'(mask), 32'd0);
        chk("t6 rst done", 32'(done), 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        seq_a("t6r");
        end_chk("t6r");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/weight_addr_gen.md
WEIGHT_ADDR_GEN -- requirements
Module: weight_addr_gen

Interface
REQ-001 SHALL have parameter S2P, default `S2P_SIZE: systolic lanes per tile (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default `ADDR_SIZE: weight-memory address width.
REQ-003 SHALL have parameter KKC_W, default 2*`KERNEL_SIZE+`CHANNELS_SIZE: width of row-length fields.
REQ-004 SHALL have parameter KN_W, default `KERNEL_NUMS_SIZE: width of the block-row count.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  level; parameters valid while high; low aborts.
REQ-008 i_w_addr_bcn  input  KKC_W  column groups per row minus 1 (ceil(L/S2P)-1).
REQ-009 i_w_addr_brn  input  KN_W  block rows, ceil(kernel_nums/S2P).
REQ-010 i_w_addr_iww  input  KKC_W  row length L in words (K*K*C).
REQ-011 i_w_addr_knr  input  S2P  valid rows in last block row minus 1, modulo 2^S2P.
REQ-012 i_w_addr_iwwr  input  S2P  valid columns in last column group minus 1, modulo 2^S2P.
REQ-013 i_w_ready  input  1  downstream accepts the current beat.
REQ-014 o_w_addr  output  ADDR_W  start address of an S2P-word row burst.
REQ-015 o_w_valid  output  1  beat valid.
REQ-016 o_w_row_vld  output  1  row is a real kernel row (not padding).
REQ-017 o_w_lane_mask  output  S2P  valid-column mask, bit j = column j of burst.
REQ-018 o_w_done  output  1  one-cycle pulse after the final accepted beat.

Function
REQ-019 States SHALL be IDLE, RUN, DONE; the FSM and all outputs SHALL be registered.
REQ-020 In IDLE with enable=1 at edge N: latch all i_w_addr_* inputs; at N+1 enter RUN with o_w_valid=1 and the first beat presented, or, if brn==0, enter DONE with o_done pulsed at N+1 and no beat.
REQ-021 Beat order: block row br 0..brn-1 (outer), column group bc 0..bcn (middle), row i 0..S2P-1 (inner).
REQ-022 o_w_addr SHALL equal (br*S2P+i)*L + bc*S2P, truncated modulo 2^ADDR_W; generated with adders only (add L per row, reload block base + bc*S2P per group), no multipliers.
REQ-023 A beat SHALL advance only on a cycle with o_w_valid && i_w_ready; otherwise o_w_addr, o_w_row_vld, o_w_lane_mask SHALL hold.
REQ-024 o_w_row_vld=0 when br==brn-1 and i > knr; knr >= S2P-1 means the block row is full.
REQ-025 o_w_lane_mask = all ones, except for bc==bcn it SHALL be the low iwwr+1 bits set (all ones when iwwr >= S2P-1); it SHALL be 0 when o_w_row_vld=0.
REQ-026 Total beats = brn*(bcn+1)*S2P; on acceptance of the last beat at edge M: o_w_valid=0 and o_w_done=1 at M+1, state DONE.
REQ-027 DONE SHALL hold o_w_valid=0, pulse done once only, and return to IDLE only when enable=0, preventing restart on a held enable.
REQ-028 enable=0 in any state SHALL at the next edge force IDLE, o_w_valid=0, o_w_done=0, counters cleared; an in-flight beat is discarded without done.
REQ-029 Input changes while in RUN SHALL have no effect (latched values used).

Reset
REQ-030 rstn=0 SHALL immediately force IDLE and o_w_addr=0, o_w_valid=0, o_w_row_vld=0, o_w_lane_mask=0, o_w_done=0, all counters 0.
REQ-031 After rstn release, operation SHALL start only from a sampled enable=1 in IDLE.

Verification
REQ-032 S2P=4, brn=1, knr=all-ones, L=8, bcn=1, iwwr=all-ones, ready=1 -> addrs 0,8,16,24,4,12,20,28, mask 1111, row_vld 1, done one cycle after last beat.
REQ-033 S2P=4, brn=2, knr=0, L=6, bcn=1, iwwr=1 -> 0,6,12,18 (1111); 4,10,16,22 (0011); 24 vld, 30,36,42 row_vld=0 mask 0000; 28 (0011), 34,40,46 row_vld=0 mask 0000; 16 beats.
REQ-034 REQ-032 setup with i_w_ready low for 3 cycles on beat 2 -> addr 16 held stable 3 cycles, sequence unchanged, no beat dropped or duplicated.
REQ-035 brn=0 with enable rising -> o_w_valid never asserts, o_w_done pulses once one cycle after enable sampled.
REQ-036 enable dropped after beat 3 of REQ-032 -> next edge valid=0, no done; re-raise enable -> sequence restarts from addr 0.
REQ-037 rstn asserted mid-RUN -> all outputs 0 asynchronously; enable held high after release -> clean restart at addr 0.
